// File: rtl/sipo_frame_if.sv
// Stream-in / frame-out bus of the SIPO frame assembler.
// The slave side is the assembler; the master side is the source/consumer pair.
interface sipo_frame_if #(
  parameter int unsigned N = 1344,
  parameter int unsigned M = 64
);
  localparam int unsigned W      = N / M;
  localparam int unsigned WordsW = $clog2(W + 1);

  logic              in_valid;
  logic [M-1:0]      in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [N-1:0]      out_data;
  logic [WordsW-1:0] out_words;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_words
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_words
  );
endinterface

// File: rtl/sipo_frame.sv
// Serial-in/parallel-out frame assembler: packs W = N/M words into one N-bit frame with
// valid/ready on both sides, selectable slot ordering and early termination (zero fill).
module sipo_frame #(
  parameter int unsigned N         = 1344,
  parameter int unsigned M         = 64,
  parameter bit          FIRST_LOW = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clear,
  sipo_frame_if.slave bus
);
  localparam int unsigned W      = N / M;
  localparam int unsigned WordsW = $clog2(W + 1);
  localparam int unsigned IdxW   = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned BitW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(W - 1);
  localparam logic [BitW-1:0] FirstBase = FIRST_LOW ? BitW'(0) : BitW'(N - M);

  if ((N % M) != 0 || N < M) begin : g_bad_ratio
    $error("sipo_frame: N must be a nonzero multiple of M");
  end

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [N-1:0]      data_q;
  logic [WordsW-1:0] words_q;
  logic              valid_q;

  logic [IdxW-1:0] slot_idx;
  logic [BitW-1:0] slot_base;
  logic [N-1:0]    fill_data;
  logic [N-1:0]    first_data;

  // fill_data: current frame with the incoming word merged in;
  // first_data: a fresh frame whose slot 0 is the incoming word.
  always_comb begin
    slot_idx   = FIRST_LOW ? idx_q : (LastIdx - idx_q);
    slot_base  = BitW'(M) * BitW'(slot_idx);
    fill_data  = data_q;
    fill_data[slot_base +: M] = bus.in_data;
    first_data = '0;
    first_data[FirstBase +: M] = bus.in_data;
  end

  // While a frame is held, input acceptance is tied to the consumer taking that frame.
  assign bus.in_ready  = rst_n & ((state_q == StFill) | bus.out_ready);
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_words = words_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      idx_q   <= '0;
      data_q  <= '0;
      words_q <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      state_q <= StFill;
      idx_q   <= '0;
      data_q  <= '0;
      words_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (bus.in_valid) begin
            data_q <= fill_data;
            if (idx_q == LastIdx || bus.in_last) begin
              state_q <= StHold;
              valid_q <= 1'b1;
              words_q <= WordsW'(idx_q) + 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              // Hand-off and first word of the next frame share one edge.
              data_q <= first_data;
              if (bus.in_last || W == 1) begin
                words_q <= WordsW'(1);
                idx_q   <= '0;
              end else begin
                state_q <= StFill;
                valid_q <= 1'b0;
                words_q <= '0;
                idx_q   <= IdxW'(1);
              end
            end else begin
              state_q <= StFill;
              valid_q <= 1'b0;
              data_q  <= '0;
              words_q <= '0;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_frame.sv
// Directed bench for sipo_frame: two instances (FIRST_LOW=1 and 0) share one stimulus stream.
module tb_sipo_frame;
  localparam int unsigned N = 256;
  localparam int unsigned M = 64;

  localparam logic [M-1:0] W11 = 64'h1111_1111_1111_1111;
  localparam logic [M-1:0] W22 = 64'h2222_2222_2222_2222;
  localparam logic [M-1:0] W33 = 64'h3333_3333_3333_3333;
  localparam logic [M-1:0] W44 = 64'h4444_4444_4444_4444;
  localparam logic [M-1:0] W55 = 64'h5555_5555_5555_5555;
  localparam logic [M-1:0] W66 = 64'h6666_6666_6666_6666;
  localparam logic [M-1:0] W77 = 64'h7777_7777_7777_7777;
  localparam logic [M-1:0] W88 = 64'h8888_8888_8888_8888;
  localparam logic [M-1:0] W99 = 64'h9999_9999_9999_9999;
  localparam logic [M-1:0] WAA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [M-1:0] WBB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [M-1:0] Z   = 64'h0;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         clear     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_last   = 1'b0;
  logic         out_ready = 1'b0;
  logic [M-1:0] in_data   = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sipo_frame_if #(.N(N), .M(M)) bus_lo ();
  sipo_frame_if #(.N(N), .M(M)) bus_hi ();

  assign bus_lo.in_valid  = in_valid;
  assign bus_lo.in_data   = in_data;
  assign bus_lo.in_last   = in_last;
  assign bus_lo.out_ready = out_ready;
  assign bus_hi.in_valid  = in_valid;
  assign bus_hi.in_data   = in_data;
  assign bus_hi.in_last   = in_last;
  assign bus_hi.out_ready = out_ready;

  sipo_frame #(.N(N), .M(M), .FIRST_LOW(1'b1)) u_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_lo)
  );

  sipo_frame #(.N(N), .M(M), .FIRST_LOW(1'b0)) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_hi)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [M-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic logic [M-1:0] seq_word(input int i);
    return 64'(i + 1) * 64'h0101_0101_0101_0101;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests_run++; if (bus_lo.out_valid !== 1'b0) begin tests_failed++;
      $display("FAIL reset_valid: got %b want 0", bus_lo.out_valid); end
    tests_run++; if (bus_lo.out_data !== '0) begin tests_failed++;
      $display("FAIL reset_data: got %h want 0", bus_lo.out_data); end
    tests_run++; if (bus_lo.out_words !== 3'd0) begin tests_failed++;
      $display("FAIL reset_words: got %0d want 0", bus_lo.out_words); end
    tests_run++; if (bus_lo.in_ready !== 1'b0) begin tests_failed++;
      $display("FAIL reset_in_ready: got %b want 0", bus_lo.in_ready); end
    #4 rst_n = 1'b1;
    step();
    tests_run++; if (bus_lo.in_ready !== 1'b1) begin tests_failed++;
      $display("FAIL post_reset_in_ready: got %b want 1", bus_lo.in_ready); end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    drive(W11, 1'b0);
    drive(W22, 1'b0);
    drive(W33, 1'b0);
    tests_run++; if (bus_lo.out_valid !== 1'b0) begin tests_failed++;
      $display("FAIL full_early_valid: got %b want 0", bus_lo.out_valid); end
    drive(W44, 1'b0);
    tests_run++; if (bus_lo.out_valid !== 1'b1 || bus_hi.out_valid !== 1'b1) begin tests_failed++;
      $display("FAIL full_valid: got %b/%b want 1/1", bus_lo.out_valid, bus_hi.out_valid); end
    tests_run++; if (bus_lo.out_data !== {W44, W33, W22, W11}) begin tests_failed++;
      $display("FAIL full_data_low: got %h want %h", bus_lo.out_data, {W44, W33, W22, W11}); end
    tests_run++; if (bus_hi.out_data !== {W11, W22, W33, W44}) begin tests_failed++;
      $display("FAIL full_data_high: got %h want %h", bus_hi.out_data, {W11, W22, W33, W44}); end
    tests_run++; if (bus_lo.out_words !== 3'd4) begin tests_failed++;
      $display("FAIL full_words: got %0d want 4", bus_lo.out_words); end
    step();
    tests_run++; if (bus_lo.out_valid !== 1'b0 || bus_lo.out_data !== '0) begin tests_failed++;
      $display("FAIL full_consume: got valid %b data %h want 0/0", bus_lo.out_valid,
               bus_lo.out_data); end
  endtask

  task automatic test_short_frame();
    out_ready = 1'b0;
    drive(WAA, 1'b0);
    drive(WBB, 1'b1);
    tests_run++; if (bus_lo.out_valid !== 1'b1) begin tests_failed++;
      $display("FAIL short_valid: got %b want 1", bus_lo.out_valid); end
    tests_run++; if (bus_lo.out_data !== {Z, Z, WBB, WAA}) begin tests_failed++;
      $display("FAIL short_data_low: got %h want %h", bus_lo.out_data, {Z, Z, WBB, WAA}); end
    tests_run++; if (bus_hi.out_data !== {WAA, WBB, Z, Z}) begin tests_failed++;
      $display("FAIL short_data_high: got %h want %h", bus_hi.out_data, {WAA, WBB, Z, Z}); end
    tests_run++; if (bus_lo.out_words !== 3'd2) begin tests_failed++;
      $display("FAIL short_words: got %0d want 2", bus_lo.out_words); end
  endtask

  // Continues from the held short frame left by test_short_frame.
  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = W77;
      #1;
      tests_run++; if (bus_lo.in_ready !== 1'b0) begin tests_failed++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus_lo.in_ready); end
      step();
      tests_run++;
      if (bus_lo.out_valid !== 1'b1 || bus_lo.out_data !== {Z, Z, WBB, WAA} ||
          bus_lo.out_words !== 3'd2) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got valid %b words %0d data %h want 1/2/%h", c,
                 bus_lo.out_valid, bus_lo.out_words, bus_lo.out_data, {Z, Z, WBB, WAA});
      end
    end
    in_data   = W55;
    out_ready = 1'b1;
    #1;
    tests_run++; if (bus_lo.in_ready !== 1'b1) begin tests_failed++;
      $display("FAIL bp_pass_through: got %b want 1", bus_lo.in_ready); end
    step();
    in_valid = 1'b0;
    tests_run++; if (bus_lo.out_valid !== 1'b0 || bus_lo.out_words !== 3'd0) begin
      tests_failed++;
      $display("FAIL bp_handoff: got valid %b words %0d want 0/0", bus_lo.out_valid,
               bus_lo.out_words); end
    tests_run++; if (bus_lo.out_data !== {Z, Z, Z, W55}) begin tests_failed++;
      $display("FAIL bp_slot0_low: got %h want %h", bus_lo.out_data, {Z, Z, Z, W55}); end
    tests_run++; if (bus_hi.out_data !== {W55, Z, Z, Z}) begin tests_failed++;
      $display("FAIL bp_slot0_high: got %h want %h", bus_hi.out_data, {W55, Z, Z, Z}); end
    drive(W66, 1'b0);
    drive(W77, 1'b0);
    drive(W88, 1'b0);
    tests_run++;
    if (bus_lo.out_valid !== 1'b1 || bus_lo.out_data !== {W88, W77, W66, W55} ||
        bus_lo.out_words !== 3'd4) begin
      tests_failed++;
      $display("FAIL bp_next_frame: got valid %b words %0d data %h want 1/4/%h",
               bus_lo.out_valid, bus_lo.out_words, bus_lo.out_data, {W88, W77, W66, W55});
    end
    step();
  endtask

  task automatic test_back_to_back();
    int frames = 0;
    logic [N-1:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = seq_word(i);
      #1;
      tests_run++; if (bus_lo.in_ready !== 1'b1) begin tests_failed++;
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus_lo.in_ready); end
      step();
      tests_run++; if (bus_lo.out_valid !== ((i % 4) == 3)) begin tests_failed++;
        $display("FAIL b2b_valid[%0d]: got %b want %b", i, bus_lo.out_valid, (i % 4) == 3); end
      if (bus_lo.out_valid === 1'b1) frames++;
      if ((i % 4) == 3) begin
        exp = {seq_word(i), seq_word(i - 1), seq_word(i - 2), seq_word(i - 3)};
        tests_run++; if (bus_lo.out_data !== exp) begin tests_failed++;
          $display("FAIL b2b_data[%0d]: got %h want %h", i, bus_lo.out_data, exp); end
      end
    end
    in_valid = 1'b0;
    step();
    tests_run++; if (frames != 3) begin tests_failed++;
      $display("FAIL b2b_frames: got %0d want 3", frames); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(W11, 1'b0);
    drive(W22, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_lo.out_data !== '0 || bus_lo.out_valid !== 1'b0 || bus_lo.out_words !== 3'd0 ||
        bus_lo.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_outputs: got valid %b words %0d ready %b data %h want all 0",
               bus_lo.out_valid, bus_lo.out_words, bus_lo.in_ready, bus_lo.out_data);
    end
    #2 rst_n = 1'b1;
    drive(W11, 1'b0);
    drive(W22, 1'b0);
    drive(W33, 1'b0);
    drive(W44, 1'b0);
    tests_run++;
    if (bus_lo.out_valid !== 1'b1 || bus_lo.out_data !== {W44, W33, W22, W11} ||
        bus_lo.out_words !== 3'd4) begin
      tests_failed++;
      $display("FAIL areset_fresh: got valid %b words %0d data %h want 1/4/%h",
               bus_lo.out_valid, bus_lo.out_words, bus_lo.out_data, {W44, W33, W22, W11});
    end
    step();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    drive(W11, 1'b0);
    drive(W22, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = W99;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (bus_lo.out_data !== '0 || bus_lo.out_valid !== 1'b0 || bus_lo.out_words !== 3'd0 ||
        bus_lo.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_outputs: got valid %b words %0d ready %b data %h want 0/0/1/0",
               bus_lo.out_valid, bus_lo.out_words, bus_lo.in_ready, bus_lo.out_data);
    end
    drive(W11, 1'b0);
    drive(W22, 1'b0);
    drive(W33, 1'b0);
    drive(W44, 1'b0);
    tests_run++;
    if (bus_lo.out_valid !== 1'b1 || bus_lo.out_data !== {W44, W33, W22, W11} ||
        bus_lo.out_words !== 3'd4) begin
      tests_failed++;
      $display("FAIL clear_fresh_low: got valid %b words %0d data %h want 1/4/%h",
               bus_lo.out_valid, bus_lo.out_words, bus_lo.out_data, {W44, W33, W22, W11});
    end
    tests_run++; if (bus_hi.out_data !== {W11, W22, W33, W44}) begin tests_failed++;
      $display("FAIL clear_fresh_high: got %h want %h", bus_hi.out_data, {W11, W22, W33, W44}); end
    step();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
